// File: rtl/multi_port_memory_controller.sv
// Multi-port generic-bus memory controller: arbitrates NUM_PORTS requesters
// onto one downstream generic-bus master port, with fixed-priority or
// round-robin arbitration and a per-transaction timeout that forces an
// error completion when the downstream slave never answers.
module multi_port_memory_controller #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_PORTS*ADDR_W-1:0]        req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]        req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0]    req_byte_en,
  input  logic [NUM_PORTS-1:0]               req_ren,
  input  logic [NUM_PORTS-1:0]               req_wen,
  output logic [NUM_PORTS-1:0]               req_busy,
  output logic [DATA_W-1:0]                  req_rdata,
  output logic [NUM_PORTS-1:0]               req_error,
  output logic [ADDR_W-1:0]                  out_addr,
  output logic [DATA_W-1:0]                  out_wdata,
  output logic [DATA_W/8-1:0]                out_byte_en,
  output logic                               out_ren,
  output logic                               out_wen,
  input  logic [DATA_W-1:0]                  out_rdata,
  input  logic                               out_busy,
  output logic [$clog2(NUM_PORTS)-1:0]       grant_idx
);

  localparam int unsigned GW      = $clog2(NUM_PORTS);
  localparam int unsigned BW      = DATA_W / 8;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] active;
  logic [GW-1:0]        winner;
  logic [GW-1:0]        idx;
  logic [GW-1:0]        next_ptr;
  logic                 found;
  logic                 timeout;
  logic                 done;
  int unsigned          p;

  assign active    = req_ren | req_wen;
  assign grant_idx = grant_q;
  assign next_ptr  = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
  assign timeout   = TO_EN && (state_q == ACCESS) && out_busy &&
                     (cnt_q == CNT_W'(TO_LAST));
  assign done      = (state_q == ACCESS) && (!out_busy || timeout);

  // Winner selection: scan from port 0 (fixed) or from rr_ptr with wrap (round-robin)
  always_comb begin
    winner = '0;
    found  = 1'b0;
    p      = 0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == 0) begin
        p = k;
      end else begin
        p = 32'(rr_ptr_q) + k;
        if (p >= NUM_PORTS) p = p - NUM_PORTS;
      end
      idx = GW'(p);
      if (!found && active[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State, grant, round-robin pointer and timeout counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: grant from IDLE, complete on slave ready or timeout
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          state_d = ACCESS;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (done) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: downstream mux from the granted port, per-port busy/error
  always_comb begin
    req_busy    = '1;
    req_error   = '0;
    req_rdata   = '0;
    out_addr    = req_addr[grant_q*ADDR_W +: ADDR_W];
    out_wdata   = req_wdata[grant_q*DATA_W +: DATA_W];
    out_byte_en = req_byte_en[grant_q*BW +: BW];
    out_ren     = 1'b0;
    out_wen     = 1'b0;
    if (state_q == ACCESS) begin
      // write wins when a requester illegally raises both strobes
      out_wen = req_wen[grant_q];
      out_ren = req_ren[grant_q] & ~req_wen[grant_q];
      if (done) begin
        req_busy[grant_q] = 1'b0;
        if (timeout) req_error[grant_q] = 1'b1;
        else         req_rdata          = out_rdata;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_memory_controller.sv
// Self-checking bench for multi_port_memory_controller: a table of single
// transactions plus directed sequences for arbitration, timeout and reset.
module tb_multi_port_memory_controller;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic [NP*BW-1:0]  req_byte_en;
  logic [NP-1:0]     req_ren, req_wen;
  logic [NP-1:0]     req_busy, req_error, req_busy_fp, req_error_fp;
  logic [DW-1:0]     req_rdata, req_rdata_fp;
  logic [AW-1:0]     out_addr, out_addr_fp;
  logic [DW-1:0]     out_wdata, out_wdata_fp;
  logic [BW-1:0]     out_byte_en, out_byte_en_fp;
  logic              out_ren, out_wen, out_ren_fp, out_wen_fp;
  logic [DW-1:0]     out_rdata;
  logic              out_busy;
  logic [1:0]        grant_idx, grant_fp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  multi_port_memory_controller #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .req_ren(req_ren), .req_wen(req_wen),
    .req_busy(req_busy), .req_rdata(req_rdata), .req_error(req_error),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_byte_en(out_byte_en),
    .out_ren(out_ren), .out_wen(out_wen), .out_rdata(out_rdata),
    .out_busy(out_busy), .grant_idx(grant_idx)
  );

  multi_port_memory_controller #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYCLES(8)
  ) dut_fp (
    .CLK(CLK), .RST(RST), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en), .req_ren(req_ren), .req_wen(req_wen),
    .req_busy(req_busy_fp), .req_rdata(req_rdata_fp), .req_error(req_error_fp),
    .out_addr(out_addr_fp), .out_wdata(out_wdata_fp), .out_byte_en(out_byte_en_fp),
    .out_ren(out_ren_fp), .out_wen(out_wen_fp), .out_rdata(out_rdata),
    .out_busy(out_busy), .grant_idx(grant_fp)
  );

  typedef struct {
    int          port;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waitc;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_busy;
    bit          exp_ren;
    bit          exp_wen;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction from IDLE: waitc busy cycles, then slave completes.
  task automatic run_vec(input vec_t v);
    @(posedge CLK); #1;
    req_addr[v.port*AW +: AW]    = v.addr;
    req_wdata[v.port*DW +: DW]   = v.wdata;
    req_byte_en[v.port*BW +: BW] = v.be;
    req_ren[v.port] = v.rd;
    req_wen[v.port] = v.wr;
    out_busy  = 1'b1;
    out_rdata = 32'hBAD0_BAD0;
    @(negedge CLK);
    chk("vec_idle_busy", req_busy, 4'hF);
    for (int c = 0; c < v.waitc; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("vec_wait_addr", out_addr, v.addr);
      chk("vec_wait_ren", out_ren, v.exp_ren);
      chk("vec_wait_wen", out_wen, v.exp_wen);
      chk("vec_wait_busy", req_busy, 4'hF);
    end
    @(posedge CLK); #1;
    out_busy  = 1'b0;
    out_rdata = v.rdata;
    @(negedge CLK);
    chk("vec_done_busy", req_busy, v.exp_busy);
    chk("vec_done_rdata", req_rdata, v.exp_rdata);
    chk("vec_done_addr", out_addr, v.addr);
    chk("vec_done_wdata", out_wdata, v.wdata);
    chk("vec_done_be", out_byte_en, v.be);
    chk("vec_done_ren", out_ren, v.exp_ren);
    chk("vec_done_wen", out_wen, v.exp_wen);
    chk("vec_done_grant", grant_idx, v.port);
    chk("vec_done_err", req_error, 4'h0);
    @(posedge CLK); #1;
    req_ren[v.port] = 1'b0;
    req_wen[v.port] = 1'b0;
    out_busy  = 1'b1;
    out_rdata = '0;
    @(negedge CLK);
    chk("vec_after_busy", req_busy, 4'hF);
    chk("vec_after_strobes", {out_ren, out_wen}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //        port rd wr addr          wdata         be     wait rdata         exp_rdata     busy    ren wen
    vecs[0] = '{1, 1, 0, 32'h0000_0100, 32'h0,        4'hF,  3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1101, 1, 0};
    vecs[1] = '{0, 0, 1, 32'h0000_0040, 32'h1234_5678, 4'b0011, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1110, 0, 1};
    vecs[2] = '{3, 1, 0, 32'hFFFF_FFFC, 32'h0,        4'hF,  1, 32'h0000_0001, 32'h0000_0001, 4'b0111, 1, 0};
    vecs[3] = '{2, 1, 1, 32'h0000_2000, 32'hA5A5_A5A5, 4'hF,  2, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'b1011, 0, 1};
    vecs[4] = '{1, 0, 1, 32'h0000_0104, 32'h0,        4'b1000, 0, 32'h0,       32'h0,        4'b1101, 0, 1};

    for (int i = 0; i < NP; i++) begin
      req_addr[i*AW +: AW]    = 32'hA000_0000 + i;
      req_wdata[i*DW +: DW]   = 32'h5000_0000 + i;
      req_byte_en[i*BW +: BW] = 4'h5;
    end
    req_ren   = '0;
    req_wen   = '0;
    out_busy  = 1'b1;
    out_rdata = '0;

    // Reset state
    #1;
    chk("rst_busy", req_busy, 4'hF);
    chk("rst_err", req_error, 4'h0);
    chk("rst_strobes", {out_ren, out_wen}, 2'b00);
    chk("rst_rdata", req_rdata, 32'h0);
    chk("rst_grant", grant_idx, 2'd0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Table of single transactions
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Round-robin vs fixed priority, all ports requesting, single-cycle slave
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    req_ren  = 4'hF;
    out_busy = 1'b0;
    @(negedge CLK);
    chk("rr_idle0_busy", req_busy, 4'hF);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rr_grant", grant_idx, k % 4);
      chk("rr_busy", req_busy, 4'hF & ~(4'h1 << (k % 4)));
      chk("fp_grant", grant_fp, 2'd0);
      chk("fp_busy", req_busy_fp, 4'b1110);
      @(posedge CLK); #1;
      if (k == 4) begin
        req_ren  = '0;
        out_busy = 1'b1;
      end
      @(negedge CLK);
      chk("rr_gap_busy", req_busy, 4'hF);
    end

    // Timeout: slave never answers
    @(posedge CLK); #1;
    req_addr[2*AW +: AW] = 32'h200;
    req_ren[2] = 1'b1;
    out_rdata  = 32'hFFFF_FFFF;
    @(negedge CLK);
    chk("to_idle_busy", req_busy, 4'hF);
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      if (c < 8) begin
        chk("to_wait_busy", req_busy, 4'hF);
        chk("to_wait_err", req_error, 4'h0);
      end else begin
        chk("to_err", req_error, 4'b0100);
        chk("to_busy", req_busy, 4'b1011);
        chk("to_rdata", req_rdata, 32'h0);
        chk("to_ren_last", out_ren, 1'b1);
      end
    end
    @(posedge CLK); #1;
    req_ren[2] = 1'b0;
    out_rdata  = '0;
    @(negedge CLK);
    chk("to_after_err", req_error, 4'h0);
    chk("to_after_ren", out_ren, 1'b0);
    v = '{3, 1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h7777_0000, 32'h7777_0000, 4'b0111, 1, 0};
    run_vec(v);

    // Move rr_ptr to 3, then reset during an outstanding read
    v = '{2, 1, 0, 32'h0000_0400, 32'h0, 4'hF, 0, 32'h1111_2222, 32'h1111_2222, 4'b1011, 1, 0};
    run_vec(v);
    @(posedge CLK); #1;
    req_addr[1*AW +: AW] = 32'h500;
    req_ren[1] = 1'b1;
    out_busy   = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rm_ren", out_ren, 1'b1);
    chk("rm_grant", grant_idx, 2'd1);
    #2 RST = 1'b1;
    #1;
    chk("rm_rst_busy", req_busy, 4'hF);
    chk("rm_rst_ren", out_ren, 1'b0);
    chk("rm_rst_grant", grant_idx, 2'd0);
    chk("rm_rst_rdata", req_rdata, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    req_ren  = 4'b1001;
    out_busy = 1'b0;
    @(negedge CLK);
    chk("rm_idle_busy", req_busy, 4'hF);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rm_restart_grant", grant_idx, 2'd0);
    chk("rm_restart_busy", req_busy, 4'b1110);
    @(posedge CLK); #1;
    req_ren  = '0;
    out_busy = 1'b1;
    @(negedge CLK);
    chk("rm_end_busy", req_busy, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_port_memory_controller.md
Name: multi_port_memory_controller

Overview:
- Parametrised successor to the two-port (icache/dcache) memory controller.
- Arbitrates NUM_PORTS generic-bus requesters onto one generic-bus master port, which feeds the bus bridge (AHB or generic).
- Arbitration mode is selectable: fixed priority or round-robin.
- Adds a per-transaction timeout with error reporting, which the two-port controller lacks.

Parameters:
NUM_PORTS, 2, number of requesting generic-bus ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
ARB_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round-robin
TIMEOUT_CYCLES, 1024, cycles in ACCESS before forced completion; 0 disables the timeout

Ports:
CLK  in  1  clock; only clock domain
RST  in  1  reset; asynchronous and active-high
req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_PORTS*DATA_W  per-port write data
req_byte_en  in  NUM_PORTS*(DATA_W/8)  per-port byte enables
req_ren  in  NUM_PORTS  per-port read request
req_wen  in  NUM_PORTS  per-port write request
req_busy  out  NUM_PORTS  per-port busy; low = transaction complete this cycle
req_rdata  out  DATA_W  read data, shared; valid for the port whose busy is low
req_error  out  NUM_PORTS  per-port one-cycle error pulse, coincident with forced completion
out_addr  out  ADDR_W  downstream address
out_wdata  out  DATA_W  downstream write data
out_byte_en  out  DATA_W/8  downstream byte enables
out_ren  out  1  downstream read
out_wen  out  1  downstream write
out_rdata  in  DATA_W  downstream read data
out_busy  in  1  downstream busy; low = complete
grant_idx  out  $clog2(NUM_PORTS)  currently or last granted port (debug)

Behaviour:
- Generic bus protocol: a requester asserts ren or wen and holds addr/wdata/byte_en stable until its busy is low for one cycle.
- A requester is active when ren|wen is set. ren and wen both high is illegal; write takes precedence.
- FSM states: IDLE, ACCESS.
- IDLE:
  - out_ren = out_wen = 0; all req_busy = 1.
  - If any port is active, select the winner, register grant_idx, clear the timeout counter, and go to ACCESS next cycle.
  - If no port is active, stay in IDLE.
- Arbitration:
  - Fixed priority: lowest-index active port wins.
  - Round-robin: search from rr_ptr upward with wrap-around (NUM_PORTS-1 wraps to 0); first active port wins.
  - rr_ptr resets to 0 and is set to grant_idx+1 (mod NUM_PORTS) on each completion.
- ACCESS:
  - out_* driven combinationally from the granted port's inputs.
  - Non-granted ports see busy = 1.
  - When out_busy == 0: req_busy[grant_idx] = 0 and req_rdata = out_rdata in the same cycle; next state IDLE.
  - Minimum turnaround: one IDLE cycle between consecutive grants. Single-cycle-slave latency is therefore 2 cycles per transaction.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter increments each ACCESS cycle with out_busy = 1.
  - When the count reaches TIMEOUT_CYCLES-1 with out_busy still 1: force completion, meaning req_busy[grant_idx] = 0, req_error[grant_idx] = 1, req_rdata = 0, and next state IDLE.
  - out_ren/out_wen deassert next cycle; the downstream transaction is abandoned.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Granted requester drops ren/wen mid-ACCESS (protocol violation): out_ren/out_wen follow the inputs; the controller still waits for out_busy low, then completes normally.
- New requests arriving during ACCESS are not considered until the next IDLE cycle. No request is lost while held.
- Reset (async, RST = 1):
  - State IDLE; grant_idx = 0; rr_ptr = 0; counter = 0.
  - req_busy all 1; req_error all 0; out_ren = out_wen = 0; req_rdata = 0.
  - Reset mid-ACCESS abandons the transaction; the requester must reissue it.
- All outputs are glitch-free from registered state plus the granted port's inputs. There is no combinational path from req_* of one port to req_busy of another.

Test Plan:
- Single read: port 1 ren, addr 0x100, slave returns 0xDEADBEEF after 3 busy cycles -> out_addr = 0x100; req_busy[1] low exactly once with req_rdata = 0xDEADBEEF; port 0 busy stays 1.
- Fixed priority (ARB_MODE = 0, NUM_PORTS = 4): ports 0, 2, 3 request continuously -> grant order 0,0,0…; ports 2 and 3 starve while port 0 holds its request.
- Round-robin (ARB_MODE = 1, NUM_PORTS = 4): all four ports request, single-cycle slave -> grant order 0,1,2,3,0; each completion spaced 2 cycles apart.
- Timeout (TIMEOUT_CYCLES = 8): out_busy stuck at 1 -> after 8 ACCESS cycles, req_error[g] pulses one cycle, req_busy[g] low, req_rdata = 0; FSM returns to IDLE; next request is granted.
- Write path: port 0 wen, wdata 0x12345678, byte_en 4'b0011 -> out_wen = 1, out_wdata and out_byte_en match; completion on out_busy low.
- Reset mid-ACCESS: assert RST asynchronously during an outstanding read -> same-cycle req_busy all 1, out_ren = 0, grant_idx = 0; after release, round-robin restarts at port 0.
